// File: rtl/expmul_max_issue.sv
// expmul_max_issue
//   Producer for the expmul score interface. Takes the raw signed Q4.4 score
//   stream of one query row (one score per key) and tracks the running row max.
//   Each accepted score produces one beat with two operand pairs:
//     (o_a, o_b) = (m_old, m_new)  rescales the O* accumulator
//     (v_a, v_b) = (s,     m_new)  scales the V vector
//   Because m_new >= m_old and m_new >= s, both exponent arguments are <= 0.
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   s_vld_in/s_in       : score stream in; s_rdy_out handshake (combinational)
//   vld_out/rdy_in      : issue beat handshake toward both expmul stages
//   o_a/o_b/v_a/v_b_out : operand pairs
//   first_out/last_out  : row framing (key 0 / key SEQ_LEN-1)
//   key_idx_out         : key index of the beat
//   row_max_out         : final max of the last completed row
//   rows_done_out       : completed rows since reset (wraps)
module expmul_max_issue #(
  parameter int                 SEQ_LEN = 64,
  parameter int                 SCORE_W = 8,
  parameter logic [SCORE_W-1:0] NEG_INF = {1'b1, {(SCORE_W-1){1'b0}}},
  localparam int                KW      = $clog2(SEQ_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_vld_in,
  input  logic [SCORE_W-1:0] s_in,
  output logic               s_rdy_out,
  output logic               vld_out,
  input  logic               rdy_in,
  output logic [SCORE_W-1:0] o_a_out,
  output logic [SCORE_W-1:0] o_b_out,
  output logic [SCORE_W-1:0] v_a_out,
  output logic [SCORE_W-1:0] v_b_out,
  output logic               first_out,
  output logic               last_out,
  output logic [KW-1:0]      key_idx_out,
  output logic [SCORE_W-1:0] row_max_out,
  output logic [15:0]        rows_done_out
);

  localparam logic [KW-1:0] LAST_IDX = KW'(SEQ_LEN - 1);

  typedef enum logic {ROW_START, ROW_MID} state_t;

  state_t             r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_m, w_m_nxt, w_m_new;
  logic [KW-1:0]      r_cnt, w_cnt_nxt;
  logic               w_acc, w_last;

  logic               r_vld, r_first, r_last;
  logic [SCORE_W-1:0] r_oa, r_ob, r_va, r_vb, r_row_max;
  logic [KW-1:0]      r_key;
  logic [15:0]        r_rows;

  // Single output register: free when empty or being drained this cycle.
  assign s_rdy_out = !r_vld || rdy_in;
  assign w_acc     = s_vld_in && s_rdy_out;
  assign w_m_new   = ($signed(s_in) > $signed(r_m)) ? s_in : r_m;
  assign w_last    = (r_cnt == LAST_IDX);

  // Per-row state advances only on accept, so stalls are invisible to it.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_cnt_nxt   = r_cnt;
    if (w_acc) begin
      case (r_state)
        ROW_START: begin
          w_m_nxt     = w_m_new;
          w_cnt_nxt   = KW'(1);
          w_state_nxt = ROW_MID;
        end
        default: begin
          if (w_last) begin
            w_m_nxt     = NEG_INF;
            w_cnt_nxt   = '0;
            w_state_nxt = ROW_START;
          end else begin
            w_m_nxt   = w_m_new;
            w_cnt_nxt = r_cnt + KW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ROW_START;
      r_m       <= NEG_INF;
      r_cnt     <= '0;
      r_vld     <= 1'b0;
      r_oa      <= '0;
      r_ob      <= '0;
      r_va      <= '0;
      r_vb      <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_key     <= '0;
      r_row_max <= '0;
      r_rows    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc) begin
        // Accept with same-cycle drain reloads without a bubble.
        r_vld   <= 1'b1;
        r_oa    <= r_m;
        r_ob    <= w_m_new;
        r_va    <= s_in;
        r_vb    <= w_m_new;
        r_first <= (r_state == ROW_START);
        r_last  <= w_last;
        r_key   <= r_cnt;
      end else if (rdy_in) begin
        r_vld <= 1'b0;
      end
      if (w_acc && w_last) begin
        r_row_max <= w_m_new;
        r_rows    <= r_rows + 16'd1;
      end
    end
  end

  assign vld_out       = r_vld;
  assign o_a_out       = r_oa;
  assign o_b_out       = r_ob;
  assign v_a_out       = r_va;
  assign v_b_out       = r_vb;
  assign first_out     = r_first;
  assign last_out      = r_last;
  assign key_idx_out   = r_key;
  assign row_max_out   = r_row_max;
  assign rows_done_out = r_rows;

endmodule

// File: doc/expmul_max_issue.md
Name: expmul_max_issue

Overview:
- Producer side of the expmul score interface. It consumes the raw Q4.4 score stream for one query row, one score per key.
- Per accepted score it tracks the running row maximum and issues one beat carrying two (a,b) operand pairs:
  - (m_old, m_new): rescales the O* accumulator expmul.
  - (s, m_new): scales the V-vector expmul.
- Sits between the QK dot-product stage and the two expmul stages. Also generates row first/last framing and the key index.

Parameters:
- SEQ_LEN, 64, keys per query row (scores per row); must be >= 2.
- SCORE_W, 8, score width, signed Q4.4.
- NEG_INF, -128 (8'h80), running-max initial value, most negative Q4.4.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_vld_in  in  1  score valid
- s_in  in  SCORE_W  signed Q4.4 score
- s_rdy_out  out  1  score accepted when s_vld_in && s_rdy_out
- vld_out  out  1  issue beat valid
- rdy_in  in  1  downstream (both expmul stages) ready
- o_a_out  out  SCORE_W  O* rescale operand a = m_old
- o_b_out  out  SCORE_W  O* rescale operand b = m_new
- v_a_out  out  SCORE_W  V scale operand a = s
- v_b_out  out  SCORE_W  V scale operand b = m_new
- first_out  out  1  beat is key 0 of a row; downstream must zero O*, ignore O* rescale
- last_out  out  1  beat is key SEQ_LEN-1; row complete after this beat
- key_idx_out  out  $clog2(SEQ_LEN)  key index of the beat
- row_max_out  out  SCORE_W  final row max; valid only with last_out
- rows_done_out  out  16  completed rows since reset, wraps at 2^16

Behaviour:
- Reset: all output registers 0; vld_out=0; running max m=NEG_INF; key counter 0; state ROW_START; rows_done_out=0.
  - s_rdy_out is combinational, so it is 1 during and after reset (output register is empty).
- Pipeline: one output register stage. s_rdy_out = !vld_out || rdy_in, combinational.
- Latency: accepted score appears on outputs the next cycle.
- Output register hold/release:
  - Holds all fields stable while vld_out && !rdy_in.
  - Cleared (vld_out→0) when rdy_in and no new accept in the same cycle.
  - Accept + downstream consume in the same cycle: register reloads; vld_out stays 1, no bubble.
- On each accept:
  - m_new = (s_in > m) ? s_in : m, signed compare.
  - o_a_out ← m, o_b_out ← m_new, v_a_out ← s_in, v_b_out ← m_new.
  - key_idx_out ← counter.
  - first_out ← (state==ROW_START).
  - last_out ← (counter==SEQ_LEN-1).
- Guarantee: o_b≥o_a and v_b≥v_a always. Exponent arguments are therefore ≤0, and the a−b difference fits 9-bit signed.
- State machine (transitions only on accept):
  - ROW_START: m ← m_new, counter ← 1, go to ROW_MID.
  - ROW_MID, counter<SEQ_LEN-1: m ← m_new, counter++.
  - ROW_MID, counter==SEQ_LEN-1:
    - row_max_out ← m_new.
    - m ← NEG_INF, counter ← 0, rows_done_out++ (wraps).
    - go to ROW_START.
- Per-row state (m, counter, state) never updates without an accept; stalls are transparent.
- First key of a row: o_a_out=NEG_INF. Downstream ignores the O* path via first_out.
- Score equal to NEG_INF at row start: m_new=NEG_INF; no special case.
- Reset mid-row: partial row discarded, next accepted score is key 0 with first_out=1. Any in-flight output beat is dropped (vld_out→0).
- row_max_out holds its value until the next last beat.

Test Plan:
- Reset then row SEQ_LEN=4, scores 0x10,0x08,0x30,0x20, rdy_in=1:
  - o_a: 0x80,0x10,0x10,0x30; o_b/v_b: 0x10,0x10,0x30,0x30; v_a = inputs.
  - first on beat0, last on beat3, row_max_out=0x30, rows_done_out=1, one beat per cycle.
- Negative scores 0xF0,0xE0,0xF8,0xC0 (signed):
  - m_new sequence 0xF0,0xF0,0xF8,0xF8; o_b≥o_a and v_b≥v_a on every beat.
- Backpressure: rdy_in=0 for 3 cycles with vld_out=1 and s_vld_in held:
  - s_rdy_out=0, outputs stable, no state change.
  - On rdy_in=1: next score issued next cycle; no loss or duplication.
- Back-to-back rows, continuous stream of 8 scores, SEQ_LEN=4:
  - Beat4 has first_out=1, o_a=0x80, key_idx=0.
  - Row2 max is independent of row1; rows_done_out=2.
- Reset asserted after key 2 with a beat pending:
  - vld_out=0 the next cycle.
  - Next score is key 0, first_out=1, o_a=0x80; rows_done_out=0.
- Random vld/rdy over 1000 rows:
  - Scoreboard matches the reference max model on every beat.
  - Exactly one last_out per SEQ_LEN beats.
